// File: rtl/window_3x3_gen_pkg.sv
// Shared constants for the 3x3 window generator.
// Defaults for pixel width and image geometry.
package window_3x3_gen_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    localparam int WIN_DIM  = 3;
    localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

    function automatic int win_idx(input int row, input int col);
        return row * WIN_DIM + col;
    endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// Enable-gated shift buffer: o_data is i_data delayed by DEPTH accepted shifts.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (i_en) begin
            mem_d[0] = i_data;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign o_data = mem_q[DEPTH-1];

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator over a raster pixel stream, two line buffers.
// Optional WINDOW_POS_EN adds window-center coordinate outputs o_cx/o_cy.
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIX_W_DEF,
    parameter int IMG_WIDTH   = IMG_W_DEF,
    parameter int IMG_HEIGHT  = IMG_H_DEF,
    localparam int XW = $clog2(IMG_WIDTH),
    localparam int YW = $clog2(IMG_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic                   i_sof,
    input  logic [PIXEL_WIDTH-1:0] i_pixel,
    output logic                   o_valid,
    output logic [PIXEL_WIDTH-1:0] o_p0,
    output logic [PIXEL_WIDTH-1:0] o_p1,
    output logic [PIXEL_WIDTH-1:0] o_p2,
    output logic [PIXEL_WIDTH-1:0] o_p3,
    output logic [PIXEL_WIDTH-1:0] o_p4,
    output logic [PIXEL_WIDTH-1:0] o_p5,
    output logic [PIXEL_WIDTH-1:0] o_p6,
    output logic [PIXEL_WIDTH-1:0] o_p7,
`ifdef WINDOW_POS_EN
    output logic [XW-1:0]          o_cx,
    output logic [YW-1:0]          o_cy,
`endif
    output logic [PIXEL_WIDTH-1:0] o_p8
);

    typedef logic [PIXEL_WIDTH-1:0] pix_t;

    logic [XW-1:0] x_q, x_d, px;
    logic [YW-1:0] y_q, y_d, py;
    pix_t          win_q [WIN_TAPS];
    pix_t          win_d [WIN_TAPS];
    pix_t          out_q [WIN_TAPS];
    pix_t          out_d [WIN_TAPS];
    logic          valid_q, valid_d;
    logic          interior;
    pix_t          lb0_out, lb1_out;

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) lb0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (i_valid),
        .i_data (i_pixel),
        .o_data (lb0_out)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) lb1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (i_valid),
        .i_data (lb0_out),
        .o_data (lb1_out)
    );

    // Start of frame overrides the counters for the accepted pixel.
    always_comb begin
        px       = i_sof ? '0 : x_q;
        py       = i_sof ? '0 : y_q;
        interior = (px >= XW'(2)) && (py >= YW'(2));
        x_d      = x_q;
        y_d      = y_q;
        win_d    = win_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        if (i_valid) begin
            if (px == XW'(IMG_WIDTH - 1)) begin
                x_d = '0;
                y_d = (py == YW'(IMG_HEIGHT - 1)) ? '0 : py + YW'(1);
            end else begin
                x_d = px + XW'(1);
                y_d = py;
            end
            for (int r = 0; r < WIN_DIM; r++) begin
                win_d[win_idx(r, 0)] = win_q[win_idx(r, 1)];
                win_d[win_idx(r, 1)] = win_q[win_idx(r, 2)];
            end
            win_d[win_idx(0, 2)] = lb1_out;
            win_d[win_idx(1, 2)] = lb0_out;
            win_d[win_idx(2, 2)] = i_pixel;
            if (interior) begin
                valid_d = 1'b1;
                out_d   = win_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < WIN_TAPS; i++) begin
                win_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            win_q   <= win_d;
            out_q   <= out_d;
        end
    end

`ifdef WINDOW_POS_EN
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (i_valid && interior) begin
            cx_d = px - XW'(1);
            cy_d = py - YW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign o_cx = cx_q;
    assign o_cy = cy_q;
`endif

    assign o_valid = valid_q;
    assign o_p0    = out_q[0];
    assign o_p1    = out_q[1];
    assign o_p2    = out_q[2];
    assign o_p3    = out_q[3];
    assign o_p4    = out_q[4];
    assign o_p5    = out_q[5];
    assign o_p6    = out_q[6];
    assign o_p7    = out_q[7];
    assign o_p8    = out_q[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 4x4 image against a frame-memory reference.
// Build with +define+WINDOW_POS_EN to also check o_cx/o_cy.
module tb_window_3x3_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          i_sof;
    logic [PW-1:0] i_pixel;
    logic          o_valid;
    logic [PW-1:0] o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8;
`ifdef WINDOW_POS_EN
    logic [XW-1:0] o_cx;
    logic [YW-1:0] o_cy;
`endif

    window_3x3_gen #(
        .PIXEL_WIDTH (PW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .i_pixel (i_pixel),
        .o_valid (o_valid),
        .o_p0    (o_p0),
        .o_p1    (o_p1),
        .o_p2    (o_p2),
        .o_p3    (o_p3),
        .o_p4    (o_p4),
        .o_p5    (o_p5),
        .o_p6    (o_p6),
        .o_p7    (o_p7),
`ifdef WINDOW_POS_EN
        .o_cx    (o_cx),
        .o_cy    (o_cy),
`endif
        .o_p8    (o_p8)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int nwin  = 0;

    // Reference: whole-frame memory indexed by the spec's raster coordinates.
    logic [PW-1:0] img [H][W];
    int            mx = 0;
    int            my = 0;
    logic          exp_valid = 1'b0;
    logic [71:0]   exp_win = '0;
    logic [XW-1:0] exp_cx = '0;
    logic [YW-1:0] exp_cy = '0;
    logic [71:0]   got_q [$];

    function automatic logic [71:0] dut_win();
        return {o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7, o_p8};
    endfunction

    // Window centered at (cx,cy) of a frame whose pixel is 4*y+x+base.
    function automatic logic [71:0] wexp(input int base, input int cx, input int cy);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[(8 - (r * 3 + c)) * 8 +: 8] = 8'(4 * (cy - 1 + r) + (cx - 1 + c) + base);
            end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("o_valid", 80'(o_valid), 80'(exp_valid));
        chk("window", 80'(dut_win()), 80'(exp_win));
`ifdef WINDOW_POS_EN
        chk("center", 80'({o_cx, o_cy}), 80'({exp_cx, exp_cy}));
`endif
    endtask

    task automatic step(input logic v, input logic s, input logic [PW-1:0] p);
        @(negedge clk);
        i_valid   = v;
        i_sof     = s;
        i_pixel   = p;
        exp_valid = 1'b0;
        if (v) begin
            if (s) begin
                mx = 0;
                my = 0;
            end
            img[my][mx] = p;
            if (mx >= 2 && my >= 2) begin
                exp_valid = 1'b1;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        exp_win[(8 - (r * 3 + c)) * 8 +: 8] = img[my - 2 + r][mx - 2 + c];
                    end
                end
                exp_cx = XW'(mx - 1);
                exp_cy = YW'(my - 1);
            end
            mx++;
            if (mx == W) begin
                mx = 0;
                my++;
                if (my == H) my = 0;
            end
        end
        @(posedge clk);
        #1;
        chk_outputs();
        if (o_valid) begin
            got_q.push_back(dut_win());
            nwin++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_valid   = 1'b0;
        i_sof     = 1'b0;
        rst_n     = 1'b0;
        mx        = 0;
        my        = 0;
        exp_valid = 1'b0;
        exp_win   = '0;
        exp_cx    = '0;
        exp_cy    = '0;
        #1;
        chk_outputs();
        @(posedge clk);
        #1;
        chk_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input int base, input bit gap, input bit sof);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                step(1'b1, sof && x == 0 && y == 0, 8'(4 * y + x + base));
                if (gap) begin
                    step(1'b0, 1'b0, 8'($urandom));
                    step(1'b0, 1'b1, 8'($urandom));
                end
            end
        end
    endtask

    task automatic chk_basic(input int base);
        chk("win_count", 80'(nwin), 80'(4));
        chk("win0", 80'(got_q[0]), 80'(wexp(base, 1, 1)));
        chk("win1", 80'(got_q[1]), 80'(wexp(base, 2, 1)));
        chk("win2", 80'(got_q[2]), 80'(wexp(base, 1, 2)));
        chk("win3", 80'(got_q[3]), 80'(wexp(base, 2, 2)));
    endtask

    task automatic clear_log();
        got_q.delete();
        nwin = 0;
    endtask

    initial begin
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_pixel = '0;
        #2;
        do_reset();

        clear_log();
        send_frame(1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'd0);
        chk("first_win_lit", 80'(got_q[0]), 80'(72'h01_02_03_05_06_07_09_0a_0b));
        chk_basic(1);

        clear_log();
        send_frame(1, 1'b1, 1'b1);
        chk_basic(1);

        send_frame(1, 1'b0, 1'b1);
        clear_log();
        send_frame(101, 1'b0, 1'b1);
        chk("win_count_f2", 80'(nwin), 80'(4));
        chk("f2_win0_lit", 80'(got_q[0]), 80'(72'h65_66_67_69_6a_6b_6d_6e_6f));

        for (int k = 0; k < 7; k++) step(1'b1, k == 0, 8'(k + 1));
        do_reset();
        clear_log();
        send_frame(1, 1'b0, 1'b0);
        chk_basic(1);

        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 8'(k + 1));
        clear_log();
        send_frame(1, 1'b0, 1'b1);
        chk_basic(1);

        step(1'b1, 1'b1, 8'($urandom));
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 80) == 0, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
